// File: rtl/prog_seq_pkg.sv
// Shared constants for the run-control sequencer: FSM encoding,
// program base table and the default HALT encoding.
package prog_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int PROG_TBL_N = 3;
  localparam logic [PROG_TBL_N-1:0][10:0] PROG_BASE = {11'd512, 11'd256, 11'd0};

  // Default HALT encoding; the top exposes it as its HALT_INSTR parameter.
  localparam logic [8:0] HALT_INSTR_DEF = 9'b111111111;

  // Base address lookup; indices past the table fall back to address 0.
  function automatic logic [10:0] prog_base(input logic [1:0] idx);
    return (int'(idx) < PROG_TBL_N) ? PROG_BASE[idx] : 11'd0;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter
  import prog_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q != '1))
      count_d = count_q + W'(1);
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// Run-control sequencer: launches programs from the base table, gates PC
// advance while running, and stops on HALT or the cycle watchdog.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int                 PC_W       = 11,
  parameter int                 INSTR_W    = 9,
  parameter int                 NUM_PROGS  = 3,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter logic [15:0]        MAX_CYCLES = 16'd4095
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic [PC_W-1:0]    ProgCtr,
  output logic               FetchEn,
  output logic               PcLoad,
  output logic [PC_W-1:0]    PcLoadVal,
  output logic               Done,
  output logic               Timeout,
  output logic [1:0]         ProgIdx,
  output logic [15:0]        CycleCount,
  output logic [PC_W-1:0]    HaltPc
);

  logic [1:0]      state_q, state_d;
  logic [1:0]      prog_idx_q, prog_idx_d, prog_idx_nxt;
  logic [PC_W-1:0] halt_pc_q, halt_pc_d;
  logic [PC_W-1:0] load_val_q, load_val_d;
  logic            timeout_q, timeout_d;
  logic            done_q, done_d;
  logic            halt_hit, wd_hit, stop;
  logic            cnt_clr, cnt_inc;
  logic [15:0]     cycle_cnt;

  // Exact 4-state match so an unknown ROM word never looks like HALT.
  assign halt_hit     = (Instruction === HALT_INSTR);
  assign wd_hit       = (cycle_cnt == (MAX_CYCLES - 16'd1));
  assign stop         = halt_hit || wd_hit;
  assign prog_idx_nxt = (prog_idx_q == 2'(NUM_PROGS - 1)) ? 2'd0 : prog_idx_q + 2'd1;

  // FSM next-state, fetch gating and status capture decode.
  always_comb begin
    state_d    = state_q;
    prog_idx_d = prog_idx_q;
    halt_pc_d  = halt_pc_q;
    load_val_d = load_val_q;
    timeout_d  = timeout_q;
    FetchEn    = 1'b0;
    PcLoad     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d    = S_LOAD;
          load_val_d = PC_W'(prog_base(prog_idx_q));
          cnt_clr    = 1'b1;
          timeout_d  = 1'b0;
        end
      end
      S_LOAD: begin
        PcLoad  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_inc = 1'b1;
        FetchEn = !stop;
        if (stop) begin
          halt_pc_d = ProgCtr;
          timeout_d = !halt_hit;   // HALT wins over a coincident watchdog
          state_d   = S_DONE;
        end
      end
      default: begin  // S_DONE
        if (Start) begin
          state_d    = S_LOAD;
          prog_idx_d = prog_idx_nxt;
          load_val_d = PC_W'(prog_base(prog_idx_nxt));
          cnt_clr    = 1'b1;
          timeout_d  = 1'b0;
        end
      end
    endcase
    done_d = (state_d == S_DONE);
  end

  // State and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      prog_idx_q <= 2'd0;
      halt_pc_q  <= '0;
      load_val_q <= '0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_idx_q <= prog_idx_d;
      halt_pc_q  <= halt_pc_d;
      load_val_q <= load_val_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
    end
  end

  sat_counter #(.W(16)) u_cycle_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cycle_cnt)
  );

  assign PcLoadVal  = load_val_q;
  assign Done       = done_q;
  assign Timeout    = timeout_q;
  assign ProgIdx    = prog_idx_q;
  assign CycleCount = cycle_cnt;
  assign HaltPc     = halt_pc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: fetch unit + ROM model around the DUT, and a
// program-walk reference model predicting each run's outcome.
module tb_prog_sequencer;

  localparam int         MAXC    = 8;
  localparam logic [8:0] HALT    = 9'h1FF;
  localparam logic [8:0] BR_SELF = 9'h1FE;  // fetch model: branch to itself

  logic        clk = 1'b0;
  logic        rst, start;
  logic [8:0]  instr;
  logic [10:0] pc;
  logic        fetch_en, pc_load, done, timeout;
  logic [10:0] load_val, halt_pc;
  logic [1:0]  prog_idx;
  logic [15:0] cyc;
  logic [8:0]  rom [0:2047];

  int n_cmp = 0;
  int n_err = 0;
  int exp_idx;
  bit in_done;

  always #5 clk = ~clk;

  assign instr = rom[pc];

  // Fetch unit model: load beats branch beats increment.
  always @(posedge clk) begin
    if (rst)                              pc <= 11'd0;
    else if (pc_load)                     pc <= load_val;
    else if (fetch_en && instr != BR_SELF) pc <= pc + 11'd1;
  end

  prog_sequencer #(.MAX_CYCLES(16'(MAXC))) dut (
    .Clk         (clk),
    .Reset       (rst),
    .Start       (start),
    .Instruction (instr),
    .ProgCtr     (pc),
    .FetchEn     (fetch_en),
    .PcLoad      (pc_load),
    .PcLoadVal   (load_val),
    .Done        (done),
    .Timeout     (timeout),
    .ProgIdx     (prog_idx),
    .CycleCount  (cyc),
    .HaltPc      (halt_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] base_of(input int i);
    return (i == 0) ? 11'd0 : (i == 1) ? 11'd256 : 11'd512;
  endfunction

  // Walk the program as the fetch unit would, one RUN cycle per step.
  task automatic model(input int b, output logic [10:0] hpc,
                       output logic [15:0] cnt, output logic to);
    int a;
    a = b; hpc = '0; cnt = '0; to = 1'b0;
    for (int n = 0; n < MAXC; n++) begin
      if (rom[a] == HALT)  begin hpc = 11'(a); cnt = 16'(n + 1); to = 1'b0; return; end
      if (n == MAXC - 1)   begin hpc = 11'(a); cnt = 16'(MAXC);  to = 1'b1; return; end
      if (rom[a] != BR_SELF) a++;
    end
  endtask

  task automatic fill(input int b, input int halt_at, input int br_at);
    for (int i = 0; i < 16; i++) rom[b + i] = 9'($urandom_range(0, 9'h1FD));
    if (br_at >= 0)   rom[b + br_at]   = BR_SELF;
    if (halt_at >= 0) rom[b + halt_at] = HALT;
  endtask

  // Launch the next program from a negedge and check the whole run.
  task automatic run(input string nm, input bit do_fill, input int halt_at,
                     input int br_at, input bit hold);
    logic [10:0] e_hpc;
    logic [15:0] e_cnt;
    logic        e_to;
    logic [10:0] b;
    int          n;
    bit          extra;
    if (in_done) exp_idx = (exp_idx + 1) % 3;
    b = base_of(exp_idx);
    if (do_fill) fill(int'(b), halt_at, br_at);
    model(int'(b), e_hpc, e_cnt, e_to);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk({nm, "_pcload"}, pc_load, 1);
    chk({nm, "_loadval"}, load_val, b);
    chk({nm, "_idx_load"}, prog_idx, exp_idx);
    chk({nm, "_fe_load"}, fetch_en, 0);
    n = 0; extra = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (pc_load) extra = 1;
    end
    start = 1'b0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_reload"}, extra, 0);
    chk({nm, "_idx"}, prog_idx, exp_idx);
    chk({nm, "_haltpc"}, halt_pc, e_hpc);
    chk({nm, "_cycles"}, cyc, e_cnt);
    chk({nm, "_timeout"}, timeout, e_to);
    chk({nm, "_fe_done"}, fetch_en, 0);
    chk({nm, "_pc"}, pc, e_hpc);
    @(negedge clk);
    chk({nm, "_pc_hold"}, pc, e_hpc);
    chk({nm, "_done_hold"}, done, 1);
    in_done = 1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 9'd0;
    rst = 1'b1; start = 1'b0; exp_idx = 0; in_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fe", fetch_en, 0);
    chk("rst_pcload", pc_load, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_idx", prog_idx, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_haltpc", halt_pc, 0);
    chk("rst_loadval", load_val, 0);
    chk("rst_pc", pc, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);

    // Fixed first program: CL R1, SET #2, CL R3, ADD R3,R1, HALT.
    rom[0] = 9'h010; rom[1] = 9'h0A2; rom[2] = 9'h030; rom[3] = 9'h0C3; rom[4] = HALT;
    run("p0", 0, -1, -1, 0);
    chk("p0_haltpc_lit", halt_pc, 4);
    chk("p0_cycles_lit", cyc, 5);

    // Chaining through programs 1, 2 and wrap to 0.
    run("p1", 1, int'($urandom_range(0, 6)), -1, 0);
    run("p2", 1, int'($urandom_range(0, 6)), -1, 0);
    run("wrap", 1, int'($urandom_range(0, 6)), -1, 0);
    chk("wrap_idx_lit", prog_idx, 0);

    // Start held through the run, watchdog, HALT on watchdog cycle.
    run("hold", 1, 5, -1, 1);
    run("wdog", 1, -1, 2, 0);
    chk("wdog_to_lit", timeout, 1);
    chk("wdog_cyc_lit", cyc, MAXC);
    run("tie", 1, 7, -1, 0);
    chk("tie_to_lit", timeout, 0);

    for (int k = 0; k < 8; k++)
      run($sformatf("rnd%0d", k), 1, int'($urandom_range(0, 11)),
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : -1,
          1'($urandom_range(0, 1)));

    // Reset three cycles into RUN, then relaunch program 0.
    fill(int'(base_of((exp_idx + 1) % 3)), 7, -1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_fe_run", fetch_en, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_fe", fetch_en, 0);
    chk("mid_cyc", cyc, 0);
    chk("mid_done", done, 0);
    chk("mid_idx", prog_idx, 0);
    chk("mid_pcload", pc_load, 0);
    chk("mid_loadval", load_val, 0);
    rst = 1'b0;
    exp_idx = 0; in_done = 0;
    @(negedge clk);
    run("relaunch", 1, 3, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
